// File: rtl/dm_access_ctrl.sv
// dm_access_ctrl: shares one single-port, word-organised data memory between
// the CPU MEM stage (port 0) and the loader/debug port (port 1).
// Round-robin arbitration, sub-word loads with sign/zero extension, and
// read-modify-write for byte/halfword stores. The memory has a 1-cycle
// registered read and a synchronous write.
module dm_access_ctrl #(
    parameter int AW    = 14,
    parameter int PORTS = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [PORTS-1:0]    req,
    input  logic [PORTS-1:0]    we,
    input  logic [2*PORTS-1:0]  size,
    input  logic [PORTS-1:0]    sext,
    input  logic [32*PORTS-1:0] addr,
    input  logic [32*PORTS-1:0] wdata,
    output logic [PORTS-1:0]    ack,
    output logic                err,
    output logic [31:0]         rdata,
    output logic [AW-3:0]       mem_addr,
    output logic                mem_re,
    output logic                mem_we,
    output logic [31:0]         mem_wdata,
    input  logic [31:0]         mem_rdata,
    output logic                busy,
    output logic                stall
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        EXT  = 3'd2,
        WR   = 3'd3,
        ERR  = 3'd4
    } state_t;

    state_t state, state_d;
    logic   rr_ptr, rr_d;

    // Next values of the registered completion outputs.
    logic [PORTS-1:0] ack_d;
    logic             err_d;
    logic [31:0]      rdata_d;

    // Arbitration result and the fields of the candidate port.
    logic        grant;
    logic        gid;
    logic        sel_we;
    logic [1:0]  sel_size;
    logic        sel_sext;
    logic [AW-1:0] sel_addr;
    logic [31:0] sel_wdata;

    // Transaction fields captured at grant; they carry no reset because the
    // FSM never consumes them before a grant has loaded them.
    logic        id_q;
    logic        we_q;
    logic [1:0]  size_q;
    logic        sext_q;
    logic [AW-1:0] addr_q;
    logic [31:0] wbuf_q;

    // Address bits above the decoded range are intentionally ignored.
    logic unused_addr_hi;
    assign unused_addr_hi = ^{addr[63:32+AW], addr[31:AW]};

    // Half must be 2-byte aligned, word (and reserved size) 4-byte aligned.
    function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] off);
        logic m;
        case (sz)
            2'b00:   m = 1'b0;
            2'b01:   m = off[0];
            default: m = (off != 2'b00);
        endcase
        return m;
    endfunction

    // Sub-word stores need a read of the target word before the write.
    function automatic logic is_subword(input logic [1:0] sz);
        return (sz == 2'b00) || (sz == 2'b01);
    endfunction

    // Pick the addressed byte/half lane of a memory word and extend it.
    function automatic logic [31:0] load_extract(input logic [31:0] w,
                                                 input logic [1:0]  sz,
                                                 input logic [1:0]  off,
                                                 input logic        sx);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = w[{off, 3'b000} +: 8];
        h = off[1] ? w[31:16] : w[15:0];
        case (sz)
            2'b00:   r = {{24{sx & b[7]}}, b};
            2'b01:   r = {{16{sx & h[15]}}, h};
            default: r = w;
        endcase
        return r;
    endfunction

    // Overlay right-aligned store data onto the addressed lane, keeping the rest.
    function automatic logic [31:0] store_merge(input logic [31:0] w,
                                                input logic [31:0] d,
                                                input logic [1:0]  sz,
                                                input logic [1:0]  off);
        logic [31:0] r;
        r = w;
        case (sz)
            2'b00: r[{off, 3'b000} +: 8] = d[7:0];
            2'b01: begin
                if (off[1])
                    r[31:16] = d[15:0];
                else
                    r[15:0] = d[15:0];
            end
            default: r = d;
        endcase
        return r;
    endfunction

    // Round-robin choice: the rr_ptr port wins a tie, otherwise the lone requester.
    always_comb begin
        gid = 1'b0;
        if (req == 2'b11)
            gid = rr_ptr;
        else
            gid = req[1];
    end

    assign sel_we    = we[gid];
    assign sel_size  = size[{gid, 1'b0} +: 2];
    assign sel_sext  = sext[gid];
    assign sel_addr  = addr[{gid, 5'b00000} +: AW];
    assign sel_wdata = wdata[{gid, 5'b00000} +: 32];

    // Next-state, grant and completion-output decode.
    always_comb begin
        state_d = state;
        rr_d    = rr_ptr;
        grant   = 1'b0;
        ack_d   = '0;
        err_d   = 1'b0;
        rdata_d = '0;
        case (state)
            IDLE: begin
                // The cycle that shows ack belongs to the finished transaction;
                // the next grant is taken in the IDLE cycle after it.
                if ((ack == '0) && (req != '0)) begin
                    grant = 1'b1;
                    if (req == 2'b11)
                        rr_d = ~rr_ptr;
                    if (misaligned(sel_size, sel_addr[1:0]))
                        state_d = ERR;
                    else if (!sel_we || is_subword(sel_size))
                        state_d = RD;
                    else
                        state_d = WR;
                end
            end
            RD: state_d = EXT;
            EXT: begin
                if (!we_q) begin
                    ack_d[id_q] = 1'b1;
                    rdata_d     = load_extract(mem_rdata, size_q, addr_q[1:0], sext_q);
                    state_d     = IDLE;
                end else begin
                    state_d = WR;
                end
            end
            WR: begin
                ack_d[id_q] = 1'b1;
                state_d     = IDLE;
            end
            ERR: begin
                ack_d[id_q] = 1'b1;
                err_d       = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, arbitration pointer and registered completion outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            rr_ptr <= 1'b0;
            ack    <= '0;
            err    <= 1'b0;
            rdata  <= '0;
        end else begin
            state  <= state_d;
            rr_ptr <= rr_d;
            ack    <= ack_d;
            err    <= err_d;
            rdata  <= rdata_d;
        end
    end

    // Capture the granted port's fields; later fold in the read-back word for RMW.
    always_ff @(posedge clk) begin
        if (grant) begin
            id_q   <= gid;
            we_q   <= sel_we;
            size_q <= sel_size;
            sext_q <= sel_sext;
            addr_q <= sel_addr;
            wbuf_q <= sel_wdata;
        end else if ((state == EXT) && we_q) begin
            wbuf_q <= store_merge(mem_rdata, wbuf_q, size_q, addr_q[1:0]);
        end
    end

    // Memory strobes are pure state decodes, so nothing reaches the memory
    // from req combinationally and a reset drops them immediately.
    assign mem_re    = (state == RD);
    assign mem_we    = (state == WR);
    assign mem_addr  = ((state == RD) || (state == WR)) ? addr_q[AW-1:2] : '0;
    assign mem_wdata = (state == WR) ? wbuf_q : '0;
    assign busy      = (state != IDLE);
    assign stall     = req[0] & ~ack[0];

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Testbench for dm_access_ctrl: models the memory behind the controller,
// drives directed scenarios plus a randomized run, and checks results against
// a behavioural model computed with shifts and masks on a word array.
module tb_dm_access_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req, we, sext;
    logic [3:0]  size;
    logic [63:0] addr, wdata;
    logic [1:0]  ack;
    logic        err;
    logic [31:0] rdata;
    logic [11:0] mem_addr;
    logic        mem_re, mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'h0;
    logic        busy, stall;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] mem [0:4095];
    logic [31:0] exp_mem [0:4095];

    logic        bd_we = 1'b0;
    logic [11:0] bd_addr = 12'h0;
    logic [31:0] bd_data = 32'h0;
    int          we_count = 0;
    logic [11:0] last_wa = 12'h0;
    logic [31:0] last_wd = 32'h0;

    dm_access_ctrl #(.AW(14), .PORTS(2)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .size(size), .sext(sext),
        .addr(addr), .wdata(wdata), .ack(ack), .err(err), .rdata(rdata),
        .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy), .stall(stall)
    );

    always #5 clk = ~clk;

    // Memory with 1-cycle registered read, synchronous write, backdoor preload.
    always @(posedge clk) begin
        if (bd_we)
            mem[bd_addr] <= bd_data;
        else if (mem_we)
            mem[mem_addr] <= mem_wdata;
        if (mem_re)
            mem_rdata <= mem[mem_addr];
        if (mem_we) begin
            we_count <= we_count + 1;
            last_wa  <= mem_addr;
            last_wd  <= mem_wdata;
        end
    end

    task automatic bd_write(input int idx, input logic [31:0] val);
        bd_addr = idx[11:0];
        bd_data = val;
        bd_we   = 1'b1;
        @(posedge clk); #1;
        bd_we   = 1'b0;
        exp_mem[idx] = val;
    endtask

    task automatic set_port(input int p, input bit w, input logic [1:0] s, input bit sx,
                            input logic [31:0] a, input logic [31:0] d);
        we[p]           = w;
        size[2*p +: 2]  = s;
        sext[p]         = sx;
        addr[32*p +: 32]  = a;
        wdata[32*p +: 32] = d;
    endtask

    // One transaction on port p; lat = cycles from req sampling to ack, -1 on timeout.
    task automatic do_txn(input int p, input bit w, input logic [1:0] s, input bit sx,
                          input logic [31:0] a, input logic [31:0] d,
                          output int lat, output logic [31:0] rd, output logic er);
        int n;
        n = 0; lat = -1; rd = 32'h0; er = 1'b0;
        set_port(p, w, s, sx, a, d);
        req[p] = 1'b1;
        while (n < 20) begin
            @(posedge clk); #1;
            n++;
            if (ack[p]) begin
                lat = n; rd = rdata; er = err;
                break;
            end
        end
        req[p] = 1'b0;
        @(posedge clk); #1;
    endtask

    // Reference model: load result from a word using shift/mask arithmetic.
    function automatic logic [31:0] model_load(input logic [31:0] word, input logic [1:0] s,
                                               input bit sx, input logic [1:0] off);
        logic [31:0] v;
        if (s == 2'd0) begin
            v = (word >> (off * 8)) & 32'hFF;
            if (sx && v >= 32'd128) v = v | 32'hFFFFFF00;
        end else if (s == 2'd1) begin
            v = (word >> ((off / 2) * 16)) & 32'hFFFF;
            if (sx && v >= 32'd32768) v = v | 32'hFFFF0000;
        end else begin
            v = word;
        end
        return v;
    endfunction

    function automatic logic [31:0] model_store(input logic [31:0] word, input logic [31:0] d,
                                                input logic [1:0] s, input logic [1:0] off);
        logic [31:0] mask;
        if (s == 2'd0) begin
            mask = 32'hFF << (off * 8);
            return (word & ~mask) | ((d & 32'hFF) << (off * 8));
        end else if (s == 2'd1) begin
            mask = 32'hFFFF << ((off / 2) * 16);
            return (word & ~mask) | ((d & 32'hFFFF) << ((off / 2) * 16));
        end
        return d;
    endfunction

    function automatic bit model_mis(input logic [1:0] s, input logic [1:0] off);
        if (s == 2'd1) return off[0];
        if (s >= 2'd2) return off != 2'd0;
        return 1'b0;
    endfunction

    task automatic test_reset;
        reset = 1'b1; req = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        vectors++; if (ack !== 2'b00) begin $display("FAIL reset_ack got=%b exp=00", ack); miscompares++; end
        vectors++; if (err !== 1'b0) begin $display("FAIL reset_err got=%b exp=0", err); miscompares++; end
        vectors++; if (rdata !== 32'h0) begin $display("FAIL reset_rdata got=%h exp=0", rdata); miscompares++; end
        vectors++; if (mem_re !== 1'b0) begin $display("FAIL reset_mem_re got=%b exp=0", mem_re); miscompares++; end
        vectors++; if (mem_we !== 1'b0) begin $display("FAIL reset_mem_we got=%b exp=0", mem_we); miscompares++; end
        vectors++; if (mem_wdata !== 32'h0) begin $display("FAIL reset_mem_wdata got=%h exp=0", mem_wdata); miscompares++; end
        vectors++; if (mem_addr !== 12'h0) begin $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); miscompares++; end
        vectors++; if (busy !== 1'b0) begin $display("FAIL reset_busy got=%b exp=0", busy); miscompares++; end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_word_store_load;
        int lat; logic [31:0] rd; logic er;
        do_txn(0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, lat, rd, er);
        vectors++; if (lat !== 2) begin $display("FAIL wstore_latency got=%0d exp=2", lat); miscompares++; end
        vectors++; if (last_wa !== 12'd4) begin $display("FAIL wstore_mem_addr got=%h exp=004", last_wa); miscompares++; end
        vectors++; if (last_wd !== 32'hDEADBEEF) begin $display("FAIL wstore_mem_wdata got=%h exp=deadbeef", last_wd); miscompares++; end
        vectors++; if (er !== 1'b0) begin $display("FAIL wstore_err got=%b exp=0", er); miscompares++; end
        do_txn(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, rd, er);
        vectors++; if (lat !== 3) begin $display("FAIL wload_latency got=%0d exp=3", lat); miscompares++; end
        vectors++; if (rd !== 32'hDEADBEEF) begin $display("FAIL wload_rdata got=%h exp=deadbeef", rd); miscompares++; end
    endtask

    task automatic test_byte_rmw;
        int lat; logic [31:0] rd; logic er;
        bd_write(4, 32'h11223344);
        do_txn(0, 1'b1, 2'b00, 1'b0, 32'h12, 32'h000000AA, lat, rd, er);
        vectors++; if (lat !== 4) begin $display("FAIL bstore_latency got=%0d exp=4", lat); miscompares++; end
        vectors++; if (last_wd !== 32'h11AA3344) begin $display("FAIL bstore_mem_wdata got=%h exp=11aa3344", last_wd); miscompares++; end
        vectors++; if (mem[4] !== 32'h11AA3344) begin $display("FAIL bstore_mem_word got=%h exp=11aa3344", mem[4]); miscompares++; end
        do_txn(1, 1'b0, 2'b00, 1'b1, 32'h12, 32'h0, lat, rd, er);
        vectors++; if (rd !== 32'hFFFFFFAA) begin $display("FAIL bload_sext got=%h exp=ffffffaa", rd); miscompares++; end
        do_txn(0, 1'b0, 2'b00, 1'b0, 32'h12, 32'h0, lat, rd, er);
        vectors++; if (rd !== 32'h000000AA) begin $display("FAIL bload_zext got=%h exp=000000aa", rd); miscompares++; end
    endtask

    task automatic test_half_load;
        int lat; logic [31:0] rd; logic er;
        bd_write(5, 32'h80017FFF);
        do_txn(0, 1'b0, 2'b01, 1'b1, 32'h16, 32'h0, lat, rd, er);
        vectors++; if (rd !== 32'hFFFF8001) begin $display("FAIL hload_off2 got=%h exp=ffff8001", rd); miscompares++; end
        do_txn(1, 1'b0, 2'b01, 1'b1, 32'h14, 32'h0, lat, rd, er);
        vectors++; if (rd !== 32'h00007FFF) begin $display("FAIL hload_off0 got=%h exp=00007fff", rd); miscompares++; end
    endtask

    task automatic test_misaligned;
        int lat; logic [31:0] rd; logic er; int wc0;
        wc0 = we_count;
        do_txn(0, 1'b0, 2'b10, 1'b0, 32'h13, 32'h0, lat, rd, er);
        vectors++; if (lat !== 2) begin $display("FAIL mis_load_latency got=%0d exp=2", lat); miscompares++; end
        vectors++; if (er !== 1'b1) begin $display("FAIL mis_load_err got=%b exp=1", er); miscompares++; end
        vectors++; if (rd !== 32'h0) begin $display("FAIL mis_load_rdata got=%h exp=0", rd); miscompares++; end
        do_txn(1, 1'b1, 2'b01, 1'b0, 32'h11, 32'h0000BEEF, lat, rd, er);
        vectors++; if (lat !== 2) begin $display("FAIL mis_store_latency got=%0d exp=2", lat); miscompares++; end
        vectors++; if (er !== 1'b1) begin $display("FAIL mis_store_err got=%b exp=1", er); miscompares++; end
        vectors++; if (we_count !== wc0) begin $display("FAIL mis_no_write got=%0d exp=%0d", we_count, wc0); miscompares++; end
        vectors++; if (mem[4] !== 32'h11AA3344) begin $display("FAIL mis_mem_word got=%h exp=11aa3344", mem[4]); miscompares++; end
    endtask

    // Both ports request continuously: grants alternate with a fixed 4-cycle cadence.
    task automatic test_contention;
        logic [1:0] exp_ack;
        bit exp_stall;
        bd_write(8, $urandom);
        bd_write(9, $urandom);
        reset = 1'b1;
        set_port(0, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
        set_port(1, 1'b0, 2'b10, 1'b0, 32'h24, 32'h0);
        req = 2'b11;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int n = 1; n <= 24; n++) begin
            @(posedge clk); #1;
            if (n % 4 == 3) exp_ack = ((n / 4) % 2 == 0) ? 2'b01 : 2'b10;
            else exp_ack = 2'b00;
            exp_stall = (n % 8 != 3);
            vectors++; if (ack !== exp_ack) begin $display("FAIL cont_ack cyc=%0d got=%b exp=%b", n, ack, exp_ack); miscompares++; end
            vectors++; if (stall !== exp_stall) begin $display("FAIL cont_stall cyc=%0d got=%b exp=%b", n, stall, exp_stall); miscompares++; end
            if (exp_ack != 2'b00) begin
                vectors++;
                if (rdata !== (exp_ack[0] ? exp_mem[8] : exp_mem[9])) begin
                    $display("FAIL cont_rdata cyc=%0d got=%h exp=%h", n, rdata, exp_ack[0] ? exp_mem[8] : exp_mem[9]);
                    miscompares++;
                end
            end
        end
        req = 2'b00;
        repeat (6) @(posedge clk);
        #1;
    endtask

    // Reset while a byte store sits in EXT: no write, no ack, pointer back to port 0.
    task automatic test_reset_mid;
        int wc0; int first_n; logic [1:0] first_ack;
        bd_write(12, 32'hCAFEF00D);
        bd_write(8, 32'h0BADCAFE);
        reset = 1'b1; req = 2'b00;
        @(posedge clk); #1;
        reset = 1'b0;
        set_port(0, 1'b1, 2'b00, 1'b0, 32'h32, 32'h0000005A);
        set_port(1, 1'b0, 2'b10, 1'b0, 32'h24, 32'h0);
        req = 2'b11;
        wc0 = we_count;
        @(posedge clk); #1;
        @(posedge clk); #1;
        vectors++; if (busy !== 1'b1) begin $display("FAIL rmid_busy_before got=%b exp=1", busy); miscompares++; end
        reset = 1'b1;
        @(posedge clk); #1;
        vectors++; if (busy !== 1'b0) begin $display("FAIL rmid_idle got=%b exp=0", busy); miscompares++; end
        vectors++; if (mem_we !== 1'b0) begin $display("FAIL rmid_mem_we got=%b exp=0", mem_we); miscompares++; end
        vectors++; if (ack !== 2'b00) begin $display("FAIL rmid_ack got=%b exp=00", ack); miscompares++; end
        set_port(0, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
        reset = 1'b0;
        first_n = -1; first_ack = 2'b00;
        for (int n = 1; n <= 12; n++) begin
            @(posedge clk); #1;
            if (first_n < 0 && ack != 2'b00) begin
                first_n = n; first_ack = ack;
                req = 2'b00;
            end
        end
        vectors++; if (first_ack !== 2'b01) begin $display("FAIL rmid_rr_ptr got=%b exp=01", first_ack); miscompares++; end
        vectors++; if (first_n !== 3) begin $display("FAIL rmid_latency got=%0d exp=3", first_n); miscompares++; end
        vectors++; if (we_count !== wc0) begin $display("FAIL rmid_no_write got=%0d exp=%0d", we_count, wc0); miscompares++; end
        vectors++; if (mem[12] !== 32'hCAFEF00D) begin $display("FAIL rmid_mem_word got=%h exp=cafef00d", mem[12]); miscompares++; end
    endtask

    task automatic test_random;
        int lat, exp_lat, p, idx; logic [31:0] rd, a, d, exp_rd; logic er;
        bit w, sx, mis; logic [1:0] s, off;
        for (int i = 0; i < 16; i++) bd_write(64 + i, $urandom);
        for (int i = 0; i < 80; i++) begin
            p   = $urandom_range(0, 1);
            w   = 1'($urandom_range(0, 1));
            sx  = 1'($urandom_range(0, 1));
            s   = 2'($urandom_range(0, 3));
            off = 2'($urandom_range(0, 3));
            idx = 64 + $urandom_range(0, 15);
            a   = ($urandom & 32'hFFFFC000) | (idx << 2) | {30'h0, off};
            d   = $urandom;
            mis = model_mis(s, off);
            exp_rd = 32'h0;
            if (mis) exp_lat = 2;
            else if (!w) begin
                exp_lat = 3;
                exp_rd = model_load(exp_mem[idx], s, sx, off);
            end else begin
                exp_lat = (s >= 2'd2) ? 2 : 4;
                exp_mem[idx] = model_store(exp_mem[idx], d, s, off);
            end
            do_txn(p, w, s, sx, a, d, lat, rd, er);
            vectors++; if (lat !== exp_lat) begin $display("FAIL rnd_latency i=%0d got=%0d exp=%0d", i, lat, exp_lat); miscompares++; end
            vectors++; if (er !== mis) begin $display("FAIL rnd_err i=%0d got=%b exp=%b", i, er, mis); miscompares++; end
            if (!w || mis) begin
                vectors++; if (rd !== exp_rd) begin $display("FAIL rnd_rdata i=%0d got=%h exp=%h", i, rd, exp_rd); miscompares++; end
            end
            vectors++; if (mem[idx] !== exp_mem[idx]) begin $display("FAIL rnd_mem i=%0d idx=%0d got=%h exp=%h", i, idx, mem[idx], exp_mem[idx]); miscompares++; end
        end
    endtask

    initial begin
        reset = 1'b1; req = 2'b00; we = 2'b00; sext = 2'b00; size = 4'h0;
        addr = 64'h0; wdata = 64'h0;
        test_reset();
        test_word_store_load();
        test_byte_rmw();
        test_half_load();
        test_misaligned();
        test_contention();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached, vectors=%0d", vectors);
        $fatal(1, "watchdog");
    end

endmodule
